// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: size encodings, FSM states and
// byte-lane masks.
package lsu_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeRsvd = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } lsu_state_e;

  localparam logic [3:0] BeByte   = 4'b0001;
  localparam logic [3:0] BeHalfLo = 4'b0011;
  localparam logic [3:0] BeHalfHi = 4'b1100;
  localparam logic [3:0] BeWord   = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and data replication, load extraction and
// extension, and alignment fault detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = rdata >> {offset, 3'b000};
    be         = BeWord;
    lane_wdata = wdata;
    load_data  = shifted;
    misalign   = 1'b0;
    case (size)
      SizeByte: begin
        be         = BeByte << offset;
        lane_wdata = {4{wdata[7:0]}};
        load_data  = is_unsigned ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SizeHalf: begin
        be         = offset[1] ? BeHalfHi : BeHalfLo;
        lane_wdata = {2{wdata[15:0]}};
        load_data  = is_unsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        misalign   = offset[0];
      end
      SizeWord: misalign = |offset;
      default:  misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding data-memory access with aligned lanes and writeback.
// Define LSU_TIMEOUT_EN to abort accesses that see no ack within TIMEOUT_CYCLES.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic        req_unsigned,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        busy,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        timeout
);

  if (TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("TIMEOUT_CYCLES must be non-zero");
  end

  lsu_state_e  state_q, state_d;
  logic [1:0]  size_q, offset_q;
  logic        unsigned_q, dmem_we_q, wb_valid_q, misalign_q;
  logic [4:0]  rd_q, wb_rd_q;
  logic [3:0]  dmem_be_q, lane_be;
  logic [31:0] dmem_addr_q, dmem_wdata_q, wb_data_q, lane_wdata, load_data;
  logic [1:0]  sel_size, sel_offset;
  logic        idle, sel_unsigned, lane_fault, accept, fault, load_done, expire;

  // One aligner serves both directions: request operands while idle, captured ones after.
  assign idle         = (state_q == StIdle);
  assign sel_size     = idle ? req_size : size_q;
  assign sel_offset   = idle ? req_addr[1:0] : offset_q;
  assign sel_unsigned = idle ? req_unsigned : unsigned_q;

  lsu_align u_align (
    .size        (sel_size),
    .offset      (sel_offset),
    .is_unsigned (sel_unsigned),
    .wdata       (req_wdata),
    .rdata       (dmem_rdata),
    .be          (lane_be),
    .lane_wdata  (lane_wdata),
    .load_data   (load_data),
    .misalign    (lane_fault)
  );

  assign accept    = idle & req_valid & ~lane_fault;
  assign fault     = idle & req_valid & lane_fault;
  assign load_done = (state_q == StWait) & dmem_ack & ~dmem_we_q;

`ifdef LSU_TIMEOUT_EN
  logic [31:0] cnt_q;
  logic        timeout_q;

  assign expire  = (state_q == StWait) & ~dmem_ack & (cnt_q == TIMEOUT_CYCLES - 1);
  assign timeout = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      if (accept) begin
        cnt_q <= '0;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = StWait;
      StWait: begin
        if (dmem_ack) begin
          state_d = dmem_we_q ? StIdle : StResp;
        end else if (expire) begin
          state_d = StIdle;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      size_q       <= '0;
      offset_q     <= '0;
      unsigned_q   <= 1'b0;
      rd_q         <= '0;
      dmem_we_q    <= 1'b0;
      dmem_be_q    <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= fault;
      wb_valid_q <= load_done & (rd_q != 5'd0);
      if (accept) begin
        size_q       <= req_size;
        offset_q     <= req_addr[1:0];
        unsigned_q   <= req_unsigned;
        rd_q         <= req_rd;
        dmem_we_q    <= req_store;
        dmem_be_q    <= lane_be;
        dmem_addr_q  <= {req_addr[31:2], 2'b00};
        dmem_wdata_q <= lane_wdata;
      end
      // Writeback regs only move when wb_valid rises, so they hold otherwise.
      if (load_done && rd_q != 5'd0) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= load_data;
      end
    end
  end

  assign busy       = ~idle;
  assign dmem_req   = (state_q == StWait);
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign misalign   = misalign_q;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of cycles waiting for dmem_ack before an abort (used only with LSU_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  memory op presented by the EX pipeline register.
REQ-005 SHALL have ports req_store  input  1 (1 = store, 0 = load) and req_unsigned  input  1 (zero-extend the load).
REQ-006 SHALL have port req_size  input  2  encoded 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-007 SHALL have ports req_addr  input  32 (byte address), req_wdata  input  32 (store data) and req_rd  input  5 (load destination).
REQ-008 SHALL have port busy  output  1  stall to the control unit.
REQ-009 SHALL have data-memory ports dmem_req  output  1, dmem_we  output  1, dmem_addr  output  32, dmem_be  output  4, dmem_wdata  output  32, dmem_ack  input  1 and dmem_rdata  input  32.
REQ-010 SHALL have writeback ports wb_valid  output  1, wb_rd  output  5 and wb_data  output  32.
REQ-011 SHALL have ports misalign  output  1 (one-cycle fault pulse) and timeout  output  1 (one-cycle abort pulse).

Function
REQ-012 SHALL implement the FSM states IDLE, WAIT and RESP; busy = (state != IDLE).
REQ-013 SHALL accept a request only in IDLE with req_valid=1; operands are captured and the FSM goes to WAIT; upstream holds the request while busy=1.
REQ-014 SHALL drive dmem_req=1 throughout WAIT, with dmem_addr = {addr[31:2],2'b00} and dmem_we/dmem_be/dmem_wdata registered and stable until the ack.
REQ-015 SHALL compute byte lanes as follows: byte: be = 1<<addr[1:0] and wdata = wdata[7:0] replicated x4; half: be = addr[1] ? 1100 : 0011 and wdata = wdata[15:0] x2; word: be = 1111.
REQ-016 SHALL respond to dmem_ack=1 in WAIT as follows: a store returns to IDLE; a load captures the aligned and extended dmem_rdata and goes to RESP.
REQ-017 SHALL extract load data from dmem_rdata shifted right by addr[1:0]*8, then sign-extend, or zero-extend when req_unsigned=1, from 8 or 16 bits.
REQ-018 SHALL in RESP assert wb_valid for exactly one cycle with wb_rd and wb_data, then return to IDLE; total load latency is accept + 1 cycle minimum to wb_valid after ack.
REQ-019 SHALL suppress wb_valid for a load with rd=0, while the memory access is still performed.
REQ-020 SHALL treat a half access with addr[0]=1, a word access with addr[1:0]!=0, or size 11 as a fault: no dmem_req, misalign pulsed for 1 cycle, FSM stays in IDLE, no writeback.
REQ-021 SHALL ignore dmem_ack outside WAIT, and SHALL ignore req_valid outside IDLE.
REQ-022 SHALL hold wb_data and wb_rd at their last value when wb_valid=0.

Reset
REQ-023 SHALL on rst=1, including mid-transaction, immediately force state to IDLE and all outputs to 0, dropping dmem_req asynchronously and discarding the pending operation.
REQ-024 SHALL, after rst deasserts, accept the first request on the first clock edge with req_valid=1.

Configuration
REQ-025 SHALL, with macro LSU_TIMEOUT_EN defined, count WAIT cycles, and after TIMEOUT_CYCLES cycles without ack drop dmem_req, pulse timeout for 1 cycle, return to IDLE and produce no writeback; the counter clears on entry to WAIT.
REQ-026 SHALL, without LSU_TIMEOUT_EN, wait indefinitely in WAIT, implement no counter, and tie timeout to 0.

Structure
REQ-027 SHALL take the size encodings, the FSM state enum and the lane-mask constants from a shared package lsu_pkg.
REQ-028 SHALL place the lane, byte-enable and extend logic in the combinational sub-module lsu_align, instantiated once for stores and once for loads, or shared.

Verification
REQ-029 SHALL cover: store word addr 0x100, data 0xDEADBEEF, ack after 3 cycles -> dmem_addr 0x100, be 1111, busy 4 cycles, no wb_valid.
REQ-030 SHALL cover: signed load byte addr 0x103, rdata 0x80xxxxxx, rd=5 -> wb_data 0xFFFFFF80, wb_rd 5, wb_valid 1 cycle after ack; the same access unsigned -> 0x00000080.
REQ-031 SHALL cover: store half addr 0x102, data 0x1234 -> be 1100, dmem_wdata 0x12341234.
REQ-032 SHALL cover: load word addr 0x101 -> misalign pulse of 1 cycle, dmem_req never asserted, busy stays 0.
REQ-033 SHALL cover: rst asserted 1 cycle into WAIT -> dmem_req 0 immediately, and a later ack is ignored.
REQ-034 SHALL cover, with LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4: no ack -> timeout pulse after 4 WAIT cycles, return to IDLE, no wb_valid.
